// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT result sequencer.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [31:0] im;
    logic [31:0] re;
  } cplx64_t;

  // Room for every read in flight plus one beat waiting on the consumer
  // and one more, so a full-rate stream never starves on credit.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/fft_seq_fifo.sv
// Small synchronous FIFO; push while full is accepted only alongside a pop.
module fft_seq_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 3,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for one FFT core: start, wait for completion, stream N result bins.
// Optional RUN-state watchdog is built when FFT_SEQ_TIMEOUT_EN is defined.
module fft_seq_ctrl
  import fft_seq_pkg::*;
#(
  parameter  int N           = 4096,
  parameter  int RD_LAT      = 1,
  parameter  int TIMEOUT_CYC = 65536,
  localparam int LEVEL       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_start,
  output logic             req_ack,
  output logic             fft_start,
  input  logic             fft_busy,
  input  logic             fft_done,
  output logic             read_en,
  output logic [LEVEL-1:0] read_addr1,
  output logic [LEVEL-1:0] read_addr2,
  input  logic [63:0]      fft_data,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             seq_busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic [2:0]       dbg_state
);

  // Handshake: a beat moves on any rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_data/out_last hold.

  localparam int                DEPTH    = fifo_depth(RD_LAT);
  localparam int                CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0]       DEPTH_V  = (CW + 1)'(DEPTH);
  localparam logic [LEVEL-1:0]  LAST_IDX = LEVEL'(N - 1);

  seq_state_t        state_q, state_d;
  logic [LEVEL-1:0]  idx_q;
  logic [LEVEL-1:0]  beat_cnt_q;
  logic              seen_busy_q;
  logic [RD_LAT-1:0] tag_pipe_q;
  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_sum;
  logic              credit_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  cplx64_t           fifo_head;
  logic              issue;
  logic              drain_exit;
  logic              run_exit;
  logic              timeout_hit;
  logic              frame_done_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  if (req_start) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        // A done level left over from the previous frame only counts once
        // busy has been observed for this frame.
        if (run_exit)         state_d = S_READ;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_READ: begin
        issue = credit_ok;
        if (credit_ok && idx_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: if (drain_exit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign run_exit   = seen_busy_q && fft_done && !fft_busy;
  assign req_ack    = (state_q == S_START);
  assign fft_start  = (state_q == S_START);
  assign read_en    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign seq_busy   = (state_q != S_IDLE);
  assign read_addr1 = read_en ? idx_q : '0;
  assign read_addr2 = read_en ? idx_q : '0;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

  // ----------------------------------------------------- credit / tags
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(tag_pipe_q[i]);
  end

  assign credit_sum = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok  = (credit_sum < DEPTH_V);
  assign fifo_push  = tag_pipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe_q   <= '0;
      idx_q        <= '0;
      beat_cnt_q   <= '0;
      seen_busy_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tag_pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      frame_done_q <= (state_q == S_DRAIN) && drain_exit;
      if (state_q == S_START) begin
        idx_q       <= '0;
        beat_cnt_q  <= '0;
        seen_busy_q <= 1'b0;
      end else begin
        if (issue && idx_q != LAST_IDX)      idx_q       <= idx_q + 1'b1;
        if (fifo_pop)                        beat_cnt_q  <= beat_cnt_q + 1'b1;
        if (state_q == S_RUN && fft_busy)    seen_busy_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- output FIFO
  fft_seq_fifo #(
    .WIDTH($bits(cplx64_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fft_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_head;
  assign out_last   = out_valid && (beat_cnt_q == LAST_IDX);
  assign fifo_pop   = out_valid && out_ready;
  assign drain_exit = fifo_pop && out_last && (in_flight == '0);

  // ---------------------------------------------------- RUN watchdog
`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_cnt_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_RUN) run_cnt_q <= '0;
    else                         run_cnt_q <= run_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == S_RUN) && (run_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)                                        err_q <= 1'b0;
    else if (state_q == S_IDLE && req_start)        err_q <= 1'b0;
    else if (timeout_hit && !run_exit)              err_q <= 1'b1;
  end

  assign err_timeout = err_q;
`else
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for one `SINGLE_FFT` instance. On a host request it pulses `fft_start` and waits for `fft_done`. It then walks the result memory through the `read_en`/`read_addr1`/`read_addr2` port and streams the N complex bins out on a valid/ready interface. A small credit-controlled FIFO absorbs the fixed memory read latency, so downstream back-pressure never loses data.

## Interface
Parameters:
- `N`, 4096: FFT size, power of two ≥ 4; `LEVEL = $clog2(N)`.
- `RD_LAT`, 1: cycles from address issue to valid `fft_data`, 1..4.
- `TIMEOUT_CYC`, 65536: max cycles allowed in RUN (used only with the timeout macro).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_start`  in  1  host request; sampled only in IDLE.
- `req_ack`  out  1  one-cycle pulse when a request is accepted.
- `fft_start`  out  1  one-cycle start pulse to the FFT.
- `fft_busy`  in  1  FFT busy level.
- `fft_done`  in  1  FFT done level; high after completion until the next start.
- `read_en`  out  1  result-port read enable.
- `read_addr1`, `read_addr2`  out  LEVEL each  result read addresses; both carry the same index.
- `fft_data`  in  64  result word, {im[63:32], re[31:0]}.
- `out_data`  out  64  streamed bin.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  marks bin N-1.
- `seq_busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted.
- `err_timeout`  out  1  sticky; cleared by `rst` or by the next accepted request.

## Operation
- States are IDLE, START, RUN, READ and DRAIN.
- IDLE
  - On `req_start`=1: go to START and pulse `req_ack`.
- START
  - `fft_start`=1 for exactly one cycle, then go to RUN.
- RUN
  - Waits for `fft_busy`=1 followed by `fft_done`=1 with `fft_busy`=0.
  - A `fft_done` still high from the previous frame is ignored until `fft_busy` has been seen high.
- READ
  - `read_en`=1.
  - A read is issued when `in_flight + fifo_count < DEPTH`, where `DEPTH = RD_LAT+2`.
  - Each issued read drives address `idx`, then increments `idx` (0..N-1, no wrap).
  - After issuing index N-1, go to DRAIN.
- DRAIN
  - `read_en` stays 1 and no new reads are issued.
  - When `in_flight`=0, the FIFO is empty and the last beat has been accepted: pulse `frame_done` and go to IDLE.
- Data path
  - A shift register of length `RD_LAT` tags issued reads.
  - When a tag emerges, `fft_data` is pushed into the FIFO.
  - The FIFO head drives `out_data`/`out_valid`.
  - `out_last` = head is bin N-1.
- Credit accounting guarantees the FIFO never overflows. Pushes while full are impossible by construction; the bench asserts this.
- `req_start` outside IDLE is ignored, with no `req_ack`.
- `read_en`=0 in IDLE, START and RUN, so the FFT owns its memory addresses then.
- `rst` at any point: IDLE next cycle, FIFO and tags flushed, `idx`=0, all outputs 0.

## Timing
- Reset values: all outputs 0.
- `req_start` high at cycle t in IDLE → `req_ack`=1 at t+1, `fft_start`=1 at t+1 (registered outputs).
- First read at the cycle RUN exits +1. Data for the read issued at cycle c is pushed at c+RD_LAT. `out_valid` appears no earlier than c+RD_LAT+1.
- With `out_ready` held at 1, throughput is one bin per cycle. Total READ+DRAIN time is N+RD_LAT+1 cycles.
- A beat transfers when `out_valid && out_ready`.
  - `out_data`/`out_last` are held stable while `out_valid && !out_ready`.
- A simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- `frame_done` pulses in the cycle after the N-th transfer, which is the same cycle `seq_busy` falls.

## Configuration
- `FFT_SEQ_TIMEOUT_EN` defined:
  - A RUN cycle counter compares against `TIMEOUT_CYC`.
  - On reaching it: `err_timeout`=1 (sticky), go to IDLE, no `frame_done`.
- Not defined:
  - No counter is built; RUN waits indefinitely.
  - `err_timeout` is tied to 0.

## Structure
- Package `fft_seq_pkg`: state enum `seq_state_t`, complex word typedef `cplx64_t` {im, re}, helper `fifo_depth(rd_lat)`.
- One sub-module, `fft_seq_fifo`: synchronous FIFO with parameterised width and depth, exposing push, pop, head, count, full and empty. The latency tag pipe stays in the top-level.

## Test plan
- N=16, RD_LAT=1, `out_ready`=1. Pulse `req_start`; model raises `fft_busy` for 40 cycles then `fft_done` → one `fft_start` pulse; 16 beats with `out_data` equal to model memory[0..15]; `out_last` on beat 15; `frame_done` one cycle later.
- Back-pressure: `out_ready` random at 30% → every beat is still delivered in order, no duplicates, FIFO count ≤ 3, data held while stalled.
- Stale `fft_done`=1 in RUN before `fft_busy` rises → controller stays in RUN and reads only after the busy→done sequence.
- `req_start` asserted during READ → no `req_ack`, frame completes normally.
- `rst` asserted mid-READ at beat 7 → all outputs 0 next cycle; a new request then produces a full clean 16-beat frame.
- With `FFT_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=100, `fft_done` never asserted → `err_timeout`=1 after 100 RUN cycles, back to IDLE; the next request clears it.
